mash_mc: RTL and testbench
==========================

Name: mash_mc

Overview:
- Parametrised multi-channel MASH modulator, the next generation of the fixed 2-channel MASH 1-1 stage.
- Quantises NUM_CH unsigned WIDTH-bit samples to DAC_BW-bit codes, with an order selectable at run time (1, 2 or 3 stages, up to MAX_ORDER).
- Per-channel LFSR dither and an AXI-stream style handshake on both sides.
- Sits between the NCO bank and the mod2 stages.

Parameters:
- NUM_CH, 2: number of parallel channels (I/Q = 2).
- WIDTH, 16: input sample and accumulator width.
- MAX_ORDER, 3: highest supported MASH order (1..3).
- DAC_BW, 5: output code width; must be >= ceil(log2(2^MAX_ORDER)).
- LFSR_W, 16: dither LFSR width per channel.

Ports:
- aclk, input, 1: clock.
- arst_n, input, 1: reset, synchronous, active-low.
- cfg_order, input, 2: requested order, 1..MAX_ORDER.
- cfg_load, input, 1: single-cycle pulse; latch cfg_order and flush.
- dither_enable, input, 1: add LFSR bit to stage-1 LSB.
- s_axis_data_tdata, input, NUM_CH*WIDTH: packed samples; channel 0 in the LSBs.
- s_axis_data_tvalid, input, 1: input valid.
- s_axis_data_tready, output, 1: input ready.
- m_axis_data_tdata, output, NUM_CH*DAC_BW: packed offset-binary codes.
- m_axis_data_tvalid, output, 1: output valid.
- m_axis_data_tready, input, 1: output ready.
- order_active, output, 2: currently applied order.

Behaviour:
- Reset (arst_n low at a rising edge of aclk):
  - all accumulators, carry delay lines and output registers cleared.
  - m_axis_data_tvalid=0, m_axis_data_tdata=0.
  - order_active=MAX_ORDER.
  - each LFSR loaded with seed 16'hACE1 XOR channel index (nonzero).
  - FSM enters RUN.
- Reset mid-operation discards any held output with no handshake.
- Handshake:
  - s_axis_data_tready = (state==RUN) && (!m_axis_data_tvalid || m_axis_data_tready).
  - A sample is accepted when s_axis_data_tvalid && s_axis_data_tready.
  - Modulator state advances only on acceptance; it is frozen during stalls.
- Latency: the code for an accepted sample appears on m_axis_data_tdata with m_axis_data_tvalid=1 on the next edge.
- m_axis_data_tvalid clears on an output handshake with no simultaneous acceptance.
- Full throughput of 1 sample/cycle holds while m_axis_data_tready=1.
- Per-channel datapath, per accepted sample n:
  - Stage-1 input: x + (dither_enable ? lfsr[0] : 0), modulo 2^WIDTH.
  - Stage 1: {c1, acc1} = acc1 + stage-1 input.
  - Stage k (k>=2): {ck, acck} = acck + new acc(k-1), same cycle (combinational chain).
  - y = c1 + (c2 - c2[n-1]) + (c3 - 2*c3[n-1] + c3[n-2]).
  - Stages above order_active are forced to zero: their accumulators hold 0 and contribute 0.
  - Output code = y + OFFSET, where OFFSET = 2^(MAX_ORDER-1) - 1 (3 at default). The code is unsigned and range-checked to 0..2^MAX_ORDER - 1.
  - The LFSR steps on every accepted sample, regardless of dither_enable.
- FSM states: RUN and FLUSH.
  - RUN -> FLUSH on cfg_load=1. order_active <= cfg_order; a cfg_order of 0 or above MAX_ORDER is clamped to MAX_ORDER.
  - FLUSH lasts exactly 1 cycle:
    - s_axis_data_tready=0.
    - all accumulators and carry delays cleared. LFSRs are not reseeded.
    - a pending output is kept and remains presentable.
  - FLUSH -> RUN unconditionally.
  - cfg_load during FLUSH is ignored.
- Simultaneous cfg_load and acceptance in the same cycle:
  - the sample is processed with the old order and its output is produced normally.
  - the flush takes effect next cycle.
- Channels are fully independent. The only shared state is the handshake and the order setting.

Decomposition:
- Package mash_pkg holds:
  - order_t (2-bit) enumerations ORDER_1/2/3.
  - the OFFSET function of MAX_ORDER.
  - the default LFSR seed and polynomial (x^16+x^14+x^13+x^11+1).
  - the FSM state typedef.
- Sub-module mash_ch: one channel holding its accumulators, carry delays, LFSR and code computation. It has advance, flush and order inputs and is instantiated NUM_CH times via generate.
- mash_mc itself holds only the handshake, FSM and packing.

Test Plan:
- Order 1, x=16'h8000 on both channels, dither off, m_axis_data_tready=1 -> codes 3,4,3,4 per channel from the first output cycle on; mean 3.5.
- Order 2, x=16'h4000, dither off -> first four codes 3,3,4,3.
- Backpressure: m_axis_data_tready=0 for 5 cycles mid-stream ->
  - s_axis_data_tready=0 throughout the stall.
  - held code stable.
  - resumed sequence identical to the unstalled golden model.
- cfg_load with cfg_order=1 while streaming at order 3 ->
  - one cycle with s_axis_data_tready=0.
  - order_active=1.
  - next output equals a fresh order-1 modulator started from zero.
- cfg_order=0 with cfg_load -> order_active=MAX_ORDER (3).
- arst_n low for 1 cycle mid-stream with output pending ->
  - next cycle m_axis_data_tvalid=0, m_axis_data_tdata=0, order_active=3.
  - following output matches a fresh golden model, dither sequence restarted from the seed.

Source files
------------

// File: rtl/mash_pkg.sv
// Shared types and constants for the multi-channel MASH modulator.
package mash_pkg;

  typedef enum logic [1:0] {
    ORDER_1 = 2'd1,
    ORDER_2 = 2'd2,
    ORDER_3 = 2'd3
  } order_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form; bit 0 is the dither bit
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Output code offset that centres the signed MASH result
  function automatic int unsigned mash_offset(input int unsigned max_order);
    return (32'd1 << (max_order - 32'd1)) - 32'd1;
  endfunction

  // Out-of-range order requests fall back to the highest supported order
  function automatic logic [1:0] clamp_order(input logic [1:0] req, input int unsigned max_order);
    if (req == 2'd0 || 32'(req) > max_order) return 2'(max_order);
    return req;
  endfunction

endpackage

// File: rtl/mash_ch.sv
// One MASH channel: cascaded accumulators, carry delay lines, dither LFSR
// and offset-binary code register.
module mash_ch
  import mash_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_ORDER = 3,
  parameter int unsigned DAC_BW    = 5,
  parameter int unsigned LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(LFSR_SEED)
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic              advance,
  input  logic              flush,
  input  logic              dither_enable,
  input  logic [1:0]        order,
  input  logic [WIDTH-1:0]  x,
  output logic [DAC_BW-1:0] code
);

  localparam int unsigned YW       = DAC_BW + 2;
  localparam int unsigned OFFSET   = mash_offset(MAX_ORDER);
  localparam int unsigned CODE_MAX = (32'd1 << MAX_ORDER) - 32'd1;

  logic [WIDTH-1:0]  acc1, acc2, acc3;
  logic              c2_d1, c3_d1, c3_d2;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [WIDTH-1:0]  stage_in;
  logic [WIDTH:0]    sum1, sum2, sum3;
  logic              en2, en3;
  logic [YW-1:0]     y;
  logic [DAC_BW-1:0] code_next;

  // Combinational accumulator chain and noise-shaping recombination
  always_comb begin
    en2       = (MAX_ORDER >= 32'd2) && (order >= ORDER_2);
    en3       = (MAX_ORDER >= 32'd3) && (order >= ORDER_3);
    lfsr_next = {^(lfsr & LFSR_W'(LFSR_TAPS)), lfsr[LFSR_W-1:1]};
    stage_in  = x + WIDTH'(dither_enable & lfsr[0]);
    sum1      = {1'b0, acc1} + {1'b0, stage_in};
    sum2      = '0;
    sum3      = '0;
    if (en2) sum2 = {1'b0, acc2} + {1'b0, sum1[WIDTH-1:0]};
    if (en3) sum3 = {1'b0, acc3} + {1'b0, sum2[WIDTH-1:0]};
    y = YW'(OFFSET) + YW'(sum1[WIDTH])
      + YW'(sum2[WIDTH]) - YW'(c2_d1)
      + YW'(sum3[WIDTH]) - (YW'(c3_d1) << 1) + YW'(c3_d2);
    if (y[YW-1]) begin
      code_next = '0;
    end else if (y > YW'(CODE_MAX)) begin
      code_next = DAC_BW'(CODE_MAX);
    end else begin
      code_next = DAC_BW'(y);
    end
  end

  // Disabled stages see zero sums, so their state settles to and holds zero
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      acc1  <= '0;
      acc2  <= '0;
      acc3  <= '0;
      c2_d1 <= 1'b0;
      c3_d1 <= 1'b0;
      c3_d2 <= 1'b0;
      lfsr  <= SEED;
      code  <= '0;
    end else if (flush) begin
      acc1  <= '0;
      acc2  <= '0;
      acc3  <= '0;
      c2_d1 <= 1'b0;
      c3_d1 <= 1'b0;
      c3_d2 <= 1'b0;
    end else if (advance) begin
      acc1  <= sum1[WIDTH-1:0];
      acc2  <= sum2[WIDTH-1:0];
      acc3  <= sum3[WIDTH-1:0];
      c2_d1 <= sum2[WIDTH];
      c3_d1 <= sum3[WIDTH];
      c3_d2 <= c3_d1;
      lfsr  <= lfsr_next;
      code  <= code_next;
    end
  end

endmodule

// File: rtl/mash_mc.sv
// Multi-channel MASH modulator: stream handshake, order/flush FSM and
// per-channel datapath instances packed onto the output bus.
module mash_mc
  import mash_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_ORDER = 3,
  parameter int unsigned DAC_BW    = 5,
  parameter int unsigned LFSR_W    = 16
) (
  input  logic                     aclk,
  input  logic                     arst_n,
  input  logic [1:0]               cfg_order,
  input  logic                     cfg_load,
  input  logic                     dither_enable,
  input  logic [NUM_CH*WIDTH-1:0]  s_axis_data_tdata,
  input  logic                     s_axis_data_tvalid,
  output logic                     s_axis_data_tready,
  output logic [NUM_CH*DAC_BW-1:0] m_axis_data_tdata,
  output logic                     m_axis_data_tvalid,
  input  logic                     m_axis_data_tready,
  output logic [1:0]               order_active
);

  state_t state;
  logic   accept;
  logic   flush;

  assign s_axis_data_tready = (state == ST_RUN) && (!m_axis_data_tvalid || m_axis_data_tready);
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;
  assign flush              = (state == ST_FLUSH);

  // A load that coincides with an accepted sample still uses the old order for it
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state              <= ST_RUN;
      order_active       <= 2'(MAX_ORDER);
      m_axis_data_tvalid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_load) begin
            state        <= ST_FLUSH;
            order_active <= clamp_order(cfg_order, MAX_ORDER);
          end
        end
        default: state <= ST_RUN;
      endcase
      if (accept) begin
        m_axis_data_tvalid <= 1'b1;
      end else if (m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    mash_ch #(
      .WIDTH    (WIDTH),
      .MAX_ORDER(MAX_ORDER),
      .DAC_BW   (DAC_BW),
      .LFSR_W   (LFSR_W),
      .SEED     (LFSR_W'(LFSR_SEED) ^ LFSR_W'(ch))
    ) u_ch (
      .aclk         (aclk),
      .arst_n       (arst_n),
      .advance      (accept),
      .flush        (flush),
      .dither_enable(dither_enable),
      .order        (order_active),
      .x            (s_axis_data_tdata[ch*WIDTH +: WIDTH]),
      .code         (m_axis_data_tdata[ch*DAC_BW +: DAC_BW])
    );
  end

endmodule

// File: tb/tb_mash_mc.sv
// Scoreboard bench for mash_mc: directed stimulus with hand-computed codes,
// a monitor pops expected codes on every output handshake.
module tb_mash_mc;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DAC_BW = 5;

  logic                     aclk = 1'b0;
  logic                     arst_n;
  logic [1:0]               cfg_order;
  logic                     cfg_load;
  logic                     dither_enable;
  logic [NUM_CH*WIDTH-1:0]  s_tdata;
  logic                     s_tvalid;
  logic                     s_tready;
  logic [NUM_CH*DAC_BW-1:0] m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic [1:0]               order_active;

  int checks   = 0;
  int failures = 0;
  logic [NUM_CH*DAC_BW-1:0] exp_q[$];

  logic [4:0] seq_o3 [6]   = '{5'd3, 5'd5, 5'd2, 5'd4, 5'd3, 5'd5};
  logic [4:0] seq_o1 [4]   = '{5'd3, 5'd4, 5'd3, 5'd4};
  logic [4:0] seq_o2 [4]   = '{5'd3, 5'd3, 5'd4, 5'd3};
  logic [4:0] seq_dth0 [6] = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd4, 5'd3};
  logic [4:0] seq_dth1 [6] = '{5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4};

  always #5 aclk = ~aclk;

  mash_mc dut (
    .aclk              (aclk),
    .arst_n            (arst_n),
    .cfg_order         (cfg_order),
    .cfg_load          (cfg_load),
    .dither_enable     (dither_enable),
    .s_axis_data_tdata (s_tdata),
    .s_axis_data_tvalid(s_tvalid),
    .s_axis_data_tready(s_tready),
    .m_axis_data_tdata (m_tdata),
    .m_axis_data_tvalid(m_tvalid),
    .m_axis_data_tready(m_tready),
    .order_active      (order_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge when valid&&ready now
  always @(negedge aclk) begin
    if (arst_n === 1'b1 && m_tvalid === 1'b1 && m_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %0h expected none", m_tdata);
      end else begin
        logic [NUM_CH*DAC_BW-1:0] e;
        e = exp_q.pop_front();
        check("code_ch0", 32'(m_tdata[DAC_BW-1:0]), 32'(e[DAC_BW-1:0]));
        check("code_ch1", 32'(m_tdata[2*DAC_BW-1:DAC_BW]), 32'(e[2*DAC_BW-1:DAC_BW]));
      end
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge
  task automatic send_cfg(input logic [15:0] x0, input logic [15:0] x1,
                          input logic [4:0] e0, input logic [4:0] e1,
                          input logic load, input logic [1:0] ord, input logic [1:0] exp_ord);
    int n;
    n         = 0;
    s_tdata   = {x1, x0};
    s_tvalid  = 1'b1;
    cfg_load  = load;
    cfg_order = ord;
    @(negedge aclk);
    while (s_tready !== 1'b1 && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (s_tready !== 1'b1) begin
      check("send_timeout", 32'(s_tready), 32'd1);
    end else begin
      exp_q.push_back({e1, e0});
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    cfg_load = 1'b0;
    if (load) begin
      check("load_flush_tready", 32'(s_tready), 32'd0);
      check("load_order_active", 32'(order_active), 32'(exp_ord));
    end
  endtask

  task automatic send(input logic [15:0] x0, input logic [15:0] x1,
                      input logic [4:0] e0, input logic [4:0] e1);
    send_cfg(x0, x1, e0, e1, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic load_cfg(input logic [1:0] ord, input logic [1:0] exp_ord);
    cfg_order = ord;
    cfg_load  = 1'b1;
    @(posedge aclk);
    #1;
    cfg_load = 1'b0;
    check("cfg_flush_tready", 32'(s_tready), 32'd0);
    check("cfg_order_active", 32'(order_active), 32'(exp_ord));
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    @(posedge aclk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_n        = 1'b0;
    cfg_order     = 2'd0;
    cfg_load      = 1'b0;
    dither_enable = 1'b0;
    s_tvalid      = 1'b0;
    s_tdata       = '0;
    m_tready      = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_order", 32'(order_active), 32'd3);
    check("rst_tready", 32'(s_tready), 32'd1);
    arst_n = 1'b1;

    // Order 3 from reset, then switch to order 1 on the same cycle as a sample
    for (int i = 0; i < 6; i++) send(16'h8000, 16'h8000, seq_o3[i], seq_o3[i]);
    send_cfg(16'h8000, 16'h8000, 5'd2, 5'd2, 1'b1, 2'd1, 2'd1);
    for (int i = 0; i < 4; i++) send(16'h8000, 16'h8000, seq_o1[i], seq_o1[i]);

    // Backpressure with a held output and a waiting input
    send(16'h8000, 16'h8000, 5'd3, 5'd3);
    m_tready = 1'b0;
    s_tdata  = {16'h8000, 16'h8000};
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_tready", 32'(s_tready), 32'd0);
      check("stall_tvalid", 32'(m_tvalid), 32'd1);
      check("stall_hold", 32'(m_tdata), 32'({5'd3, 5'd3}));
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send(16'h8000, 16'h8000, 5'd4, 5'd4);
    send(16'h8000, 16'h8000, 5'd3, 5'd3);
    send(16'h8000, 16'h8000, 5'd4, 5'd4);

    // Order 2, then an invalid order request
    load_cfg(2'd2, 2'd2);
    for (int i = 0; i < 4; i++) send(16'h4000, 16'h4000, seq_o2[i], seq_o2[i]);
    load_cfg(2'd0, 2'd3);

    // Dither at order 1, then reset with an output pending
    pulse_reset();
    load_cfg(2'd1, 2'd1);
    dither_enable = 1'b1;
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'h8000, seq_dth0[i], seq_dth1[i]);
    m_tready = 1'b0;
    arst_n   = 1'b0;
    check("pending_before_reset", 32'(exp_q.size()), 32'd1);
    @(posedge aclk);
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_tdata", 32'(m_tdata), 32'd0);
    check("midrst_order", 32'(order_active), 32'd3);
    exp_q.delete();
    arst_n   = 1'b1;
    m_tready = 1'b1;
    load_cfg(2'd1, 2'd1);
    for (int i = 0; i < 6; i++) send(16'hFFFF, 16'h8000, seq_dth0[i], seq_dth1[i]);

    s_tvalid = 1'b0;
    repeat (4) @(posedge aclk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
